wb_rr_arbiter: RTL and testbench

//  Round-robin Wishbone B3 arbiter: shares one slave bus between NM masters (CPU inst, CPU data, LCD DMA).

---
 rtl/wb_rr_arbiter_if.sv | 58 +++++
 rtl/wb_rr_arbiter.sv | 173 +++++++++++++++++
 tb/tb_wb_rr_arbiter.sv | 203 ++++++++++++++++++++
 3 files changed

// File: rtl/wb_rr_arbiter_if.sv
// ---------------------------------------------------------------------------
// wb_rr_arbiter_if
// Purpose : Bundles the Wishbone B3 signals that pass through the round-robin
//           arbiter. The master side is a packed array of NM masters. The
//           slave side is a single shared bus.
// Ports   : m_cyc_i/m_stb_i/m_we_i [NM], m_sel_i [NM*SW], m_adr_i [NM*AW],
//           m_dat_i [NM*DW]      : requests from the master array
//           m_dat_o [DW], m_ack_o/m_err_o/m_rty_o [NM] : responses to masters
//           s_cyc_o/s_stb_o/s_we_o, s_sel_o [SW], s_adr_o [AW], s_dat_o [DW]
//                                  : owner's cycle presented to the slave
//           s_dat_i [DW], s_ack_i/s_err_i/s_rty_i : slave responses
// Modports: slave  - the arbiter's view. It accepts the master array and
//                    drives the shared slave bus.
//           master - the environment's view: the master array plus the slave.
// ---------------------------------------------------------------------------
interface wb_rr_arbiter_if #(
  parameter int NM = 3,
  parameter int AW = 32,
  parameter int DW = 32
);
  localparam int SW = DW / 8;

  logic [NM-1:0]    m_cyc_i;
  logic [NM-1:0]    m_stb_i;
  logic [NM-1:0]    m_we_i;
  logic [NM*SW-1:0] m_sel_i;
  logic [NM*AW-1:0] m_adr_i;
  logic [NM*DW-1:0] m_dat_i;
  logic [DW-1:0]    m_dat_o;
  logic [NM-1:0]    m_ack_o;
  logic [NM-1:0]    m_err_o;
  logic [NM-1:0]    m_rty_o;

  logic             s_cyc_o;
  logic             s_stb_o;
  logic             s_we_o;
  logic [SW-1:0]    s_sel_o;
  logic [AW-1:0]    s_adr_o;
  logic [DW-1:0]    s_dat_o;
  logic [DW-1:0]    s_dat_i;
  logic             s_ack_i;
  logic             s_err_i;
  logic             s_rty_i;

  modport slave (
    input  m_cyc_i, m_stb_i, m_we_i, m_sel_i, m_adr_i, m_dat_i,
    output m_dat_o, m_ack_o, m_err_o, m_rty_o,
    output s_cyc_o, s_stb_o, s_we_o, s_sel_o, s_adr_o, s_dat_o,
    input  s_dat_i, s_ack_i, s_err_i, s_rty_i
  );

  modport master (
    output m_cyc_i, m_stb_i, m_we_i, m_sel_i, m_adr_i, m_dat_i,
    input  m_dat_o, m_ack_o, m_err_o, m_rty_o,
    input  s_cyc_o, s_stb_o, s_we_o, s_sel_o, s_adr_o, s_dat_o,
    output s_dat_i, s_ack_i, s_err_i, s_rty_i
  );
endinterface

// File: rtl/wb_rr_arbiter.sv
// ---------------------------------------------------------------------------
// wb_rr_arbiter
// Purpose : Round-robin Wishbone B3 arbiter. It shares one slave bus between NM
//           masters (CPU inst, CPU data, LCD DMA). A master keeps its grant for
//           its whole CYC. Each handover has one dead cycle.
// Ports   : clk     - clock. All logic runs on the rising edge.
//           rst     - synchronous reset, active-high
//           bus     - wb_rr_arbiter_if.slave. It carries the master array and
//                     the shared slave bus.
//           grant_o - one-hot registered owner. It is 0 when idle.
//           busy_o  - 1 while a master owns the bus (GRANT) or while the
//                     arbiter waits out a watchdog abort (RECOVER).
// Config  : Define WB_ARB_WATCHDOG_EN to add the watchdog. If the slave gives
//           no ack/err/rty for TIMEOUT cycles, the owner gets an error and
//           the arbiter waits in RECOVER until the owner drops CYC.
//           Without the macro the grant lasts until the owner drops CYC.
// ---------------------------------------------------------------------------
module wb_rr_arbiter #(
  parameter int NM      = 3,
  parameter int AW      = 32,
  parameter int DW      = 32,
  parameter int TIMEOUT = 1023
) (
  input  logic          clk,
  input  logic          rst,
  wb_rr_arbiter_if.slave bus,
  output logic [NM-1:0] grant_o,
  output logic          busy_o
);
  localparam int SW = DW / 8;
  localparam int IW = (NM > 1) ? $clog2(NM) : 1;
  localparam logic [NM-1:0] ONE = NM'(1);

`ifdef WB_ARB_WATCHDOG_EN
  typedef enum logic [1:0] {IDLE, GRANT, RECOVER} state_t;
  localparam int WW = $clog2(TIMEOUT + 1);
  logic [WW-1:0] wdog_q;
  logic          slaveTerm;
  logic          timeoutHit;
`else
  typedef enum logic [0:0] {IDLE, GRANT} state_t;
`endif

  state_t        state_q;
  logic [NM-1:0] grant_q;
  // last_q holds the most recently granted master. It is also the current
  // owner while in GRANT/RECOVER, so no separate owner index is kept.
  logic [IW-1:0] last_q;
  logic [IW-1:0] pickIdx;
  logic          pickValid;
  logic          ownerCyc;
  logic          inGrant;

  assign ownerCyc = bus.m_cyc_i[last_q];
  assign inGrant  = (state_q == GRANT);
  assign grant_o  = grant_q;
  assign busy_o   = (state_q != IDLE);

`ifdef WB_ARB_WATCHDOG_EN
  // A termination in the same cycle as the timeout wins. The counter
  // clears and no error is raised.
  assign slaveTerm  = bus.s_ack_i | bus.s_err_i | bus.s_rty_i;
  assign timeoutHit = inGrant && (wdog_q == WW'(TIMEOUT)) && !slaveTerm;
`endif

  // Circular search starting just after the last owner. The loop runs from
  // the farthest candidate down to the nearest, so the nearest requester is
  // the one left in pickIdx. A master that just released therefore ranks
  // last.
  always_comb begin
    pickIdx   = last_q;
    pickValid = 1'b0;
    for (int k = NM; k >= 1; k--) begin
      int idx;
      idx = int'(last_q) + k;
      if (idx >= NM) idx = idx - NM;
      if (bus.m_cyc_i[idx]) begin
        pickIdx   = IW'(idx);
        pickValid = 1'b1;
      end
    end
  end

  // Bus routing. Only the owner's cycle reaches the slave, and only the
  // owner sees terminations. Outside GRANT everything is quiet, so
  // terminations in IDLE are discarded. Read data is broadcast.
  always_comb begin
    bus.m_dat_o = bus.s_dat_i;
    bus.m_ack_o = '0;
    bus.m_err_o = '0;
    bus.m_rty_o = '0;
    bus.s_cyc_o = 1'b0;
    bus.s_stb_o = 1'b0;
    bus.s_we_o  = 1'b0;
    bus.s_sel_o = '0;
    bus.s_adr_o = '0;
    bus.s_dat_o = '0;
    if (inGrant) begin
      bus.s_cyc_o         = ownerCyc;
      bus.s_stb_o         = bus.m_stb_i[last_q];
      bus.s_we_o          = bus.m_we_i[last_q];
      bus.s_sel_o         = bus.m_sel_i[last_q*SW +: SW];
      bus.s_adr_o         = bus.m_adr_i[last_q*AW +: AW];
      bus.s_dat_o         = bus.m_dat_i[last_q*DW +: DW];
      bus.m_ack_o[last_q] = bus.s_ack_i;
      bus.m_err_o[last_q] = bus.s_err_i;
      bus.m_rty_o[last_q] = bus.s_rty_i;
`ifdef WB_ARB_WATCHDOG_EN
      if (timeoutHit) begin
        bus.s_cyc_o         = 1'b0;
        bus.s_stb_o         = 1'b0;
        bus.m_err_o[last_q] = 1'b1;
      end
`endif
    end
  end

  // Arbitration FSM. Reset makes master NM-1 the last owner, so master 0
  // wins first. Releasing goes through IDLE, which gives the dead cycle
  // between owners and lets a lone requester be granted again.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      grant_q <= '0;
      last_q  <= IW'(NM - 1);
`ifdef WB_ARB_WATCHDOG_EN
      wdog_q  <= '0;
`endif
    end else begin
      case (state_q)
        IDLE: begin
          if (pickValid) begin
            state_q <= GRANT;
            grant_q <= ONE << pickIdx;
            last_q  <= pickIdx;
`ifdef WB_ARB_WATCHDOG_EN
            wdog_q  <= '0;
`endif
          end
        end
        GRANT: begin
`ifdef WB_ARB_WATCHDOG_EN
          if (slaveTerm) wdog_q <= '0;
          else if (wdog_q != WW'(TIMEOUT)) wdog_q <= wdog_q + 1'b1;
          if (timeoutHit) begin
            state_q <= RECOVER;
          end else if (!ownerCyc) begin
            state_q <= IDLE;
            grant_q <= '0;
          end
`else
          if (!ownerCyc) begin
            state_q <= IDLE;
            grant_q <= '0;
          end
`endif
        end
`ifdef WB_ARB_WATCHDOG_EN
        RECOVER: begin
          if (!ownerCyc) begin
            state_q <= IDLE;
            grant_q <= '0;
          end
        end
`endif
        default: begin
          state_q <= IDLE;
          grant_q <= '0;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_wb_rr_arbiter.sv
// ---------------------------------------------------------------------------
// tb_wb_rr_arbiter
// Purpose : Directed testbench for wb_rr_arbiter with NM=3, AW=32, DW=32 and
//           TIMEOUT=15. The watchdog steps run only when WB_ARB_WATCHDOG_EN is
//           defined.
// ---------------------------------------------------------------------------
module tb_wb_rr_arbiter;
  logic       clk;
  logic       rst;
  logic [2:0] grant;
  logic       busy;
  int         assertCount;
  int         failCount;

  wb_rr_arbiter_if #(.NM(3), .AW(32), .DW(32)) bus ();

  wb_rr_arbiter #(.NM(3), .AW(32), .DW(32), .TIMEOUT(15)) dut (
    .clk     (clk),
    .rst     (rst),
    .bus     (bus.slave),
    .grant_o (grant),
    .busy_o  (busy)
  );

  // The clock has a 10 ns period with rising edges at 5, 15, 25, ...
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // This hard time limit makes sure the run always ends.
  initial begin
    #200000;
    $display("[TB] FAIL timeout: simulation did not finish, observed running required finished");
    $fatal(1, "[TB] time limit exceeded");
  end

  // Drives one cycle of inputs on the falling edge. It then lets the
  // combinational outputs settle before any checks run.
  task automatic applyStimulus(input logic [2:0] cyc, input logic [2:0] stb,
                               input logic [2:0] we, input logic ack,
                               input logic err, input logic rty);
    @(negedge clk);
    bus.m_cyc_i = cyc;
    bus.m_stb_i = stb;
    bus.m_we_i  = we;
    bus.s_ack_i = ack;
    bus.s_err_i = err;
    bus.s_rty_i = rty;
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [63:0] observed,
                             input logic [63:0] expected);
    assertCount++;
    assert (observed === expected) else begin
      failCount++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
    end
  endtask

  logic [2:0]  expGrant [4];
  logic [31:0] expAdr   [4];

  initial begin
    assertCount = 0;
    failCount   = 0;
    expGrant    = '{3'b001, 3'b010, 3'b100, 3'b001};
    expAdr      = '{32'h1000_0000, 32'h1000_0100, 32'h1000_0200, 32'h1000_0000};

    bus.m_cyc_i = '0;
    bus.m_stb_i = '0;
    bus.m_we_i  = '0;
    bus.m_sel_i = {4'b1100, 4'b0011, 4'b1111};
    bus.m_adr_i = {32'h1000_0200, 32'h1000_0100, 32'h1000_0000};
    bus.m_dat_i = {32'h2222_2222, 32'h1111_1111, 32'hA5A5_0000};
    bus.s_dat_i = 32'h0;
    bus.s_ack_i = 1'b0;
    bus.s_err_i = 1'b0;
    bus.s_rty_i = 1'b0;

    // Reset: the arbiter is idle and a stray slave ack is not routed.
    rst = 1'b1;
    applyStimulus(3'b000, 3'b000, 3'b000, 1'b0, 1'b0, 1'b0);
    applyStimulus(3'b000, 3'b000, 3'b000, 1'b1, 1'b0, 1'b0);
    rst = 1'b0;
    checkOutput("reset_grant", 64'(grant), 64'h0);
    checkOutput("reset_busy", 64'(busy), 64'h0);
    checkOutput("reset_s_cyc", 64'(bus.s_cyc_o), 64'h0);
    checkOutput("reset_m_ack", 64'(bus.m_ack_o), 64'h0);

    // Three masters request continuously. Each one ends after one ack.
    // The sequence is idle, grant+ack, release, then idle again.
    for (int r = 0; r < 4; r++) begin
      applyStimulus(3'b111, 3'b000, 3'b000, 1'b0, 1'b0, 1'b0);
      checkOutput("rr_idle_grant", 64'(grant), 64'h0);
      applyStimulus(3'b111, 3'b111, 3'b000, 1'b1, 1'b0, 1'b0);
      checkOutput("rr_grant", 64'(grant), 64'(expGrant[r]));
      checkOutput("rr_s_cyc", 64'(bus.s_cyc_o), 64'h1);
      checkOutput("rr_m_ack", 64'(bus.m_ack_o), 64'(expGrant[r]));
      checkOutput("rr_s_adr", 64'(bus.s_adr_o), 64'(expAdr[r]));
      applyStimulus(3'b111 & ~expGrant[r], 3'b000, 3'b000, 1'b0, 1'b0, 1'b0);
      checkOutput("rr_release_grant", 64'(grant), 64'(expGrant[r]));
      checkOutput("rr_release_s_cyc", 64'(bus.s_cyc_o), 64'h0);
    end

    // Master 1 runs alone with a 4-beat burst. STB toggles and CYC is held.
    applyStimulus(3'b010, 3'b000, 3'b000, 1'b0, 1'b0, 1'b0);
    checkOutput("burst_idle_grant", 64'(grant), 64'h0);
    for (int b = 0; b < 4; b++) begin
      applyStimulus(3'b010, 3'b010, 3'b000, 1'b1, 1'b0, 1'b0);
      checkOutput("burst_grant", 64'(grant), 64'h2);
      checkOutput("burst_m_ack", 64'(bus.m_ack_o), 64'h2);
      applyStimulus(3'b010, 3'b000, 3'b000, 1'b0, 1'b0, 1'b0);
      checkOutput("burst_gap_grant", 64'(grant), 64'h2);
      checkOutput("burst_gap_s_stb", 64'(bus.s_stb_o), 64'h0);
      checkOutput("burst_gap_m_ack", 64'(bus.m_ack_o), 64'h0);
    end
    applyStimulus(3'b000, 3'b000, 3'b000, 1'b0, 1'b0, 1'b0);
    checkOutput("burst_release_s_cyc", 64'(bus.s_cyc_o), 64'h0);

    // Master 0 owns the bus while master 2 requests. There is no preemption.
    applyStimulus(3'b001, 3'b000, 3'b000, 1'b0, 1'b0, 1'b0);
    checkOutput("hold_idle_grant", 64'(grant), 64'h0);
    applyStimulus(3'b001, 3'b001, 3'b000, 1'b1, 1'b0, 1'b0);
    checkOutput("hold_grant0", 64'(grant), 64'h1);
    applyStimulus(3'b101, 3'b001, 3'b000, 1'b0, 1'b0, 1'b0);
    checkOutput("hold_grant1", 64'(grant), 64'h1);
    applyStimulus(3'b101, 3'b001, 3'b000, 1'b1, 1'b0, 1'b0);
    checkOutput("hold_grant2", 64'(grant), 64'h1);
    checkOutput("hold_m_ack", 64'(bus.m_ack_o), 64'h1);
    applyStimulus(3'b100, 3'b000, 3'b000, 1'b0, 1'b0, 1'b0);
    checkOutput("hold_release_grant", 64'(grant), 64'h1);
    applyStimulus(3'b100, 3'b000, 3'b000, 1'b0, 1'b0, 1'b0);
    checkOutput("hold_dead_grant", 64'(grant), 64'h0);
    checkOutput("hold_dead_busy", 64'(busy), 64'h0);
    applyStimulus(3'b100, 3'b100, 3'b000, 1'b0, 1'b0, 1'b0);
    checkOutput("hold_switch_grant", 64'(grant), 64'h4);
    checkOutput("hold_switch_s_adr", 64'(bus.s_adr_o), 64'h1000_0200);
    applyStimulus(3'b000, 3'b000, 3'b000, 1'b0, 1'b0, 1'b0);

    // Idle-time ack is discarded. Then master 0 does read, write+err and rty.
    bus.s_dat_i = 32'hDEAD_BEEF;
    applyStimulus(3'b001, 3'b000, 3'b000, 1'b1, 1'b0, 1'b0);
    checkOutput("idle_ack_dropped", 64'(bus.m_ack_o), 64'h0);
    applyStimulus(3'b001, 3'b001, 3'b000, 1'b1, 1'b0, 1'b0);
    checkOutput("read_m_dat", 64'(bus.m_dat_o), 64'hDEAD_BEEF);
    checkOutput("read_m_ack", 64'(bus.m_ack_o), 64'h1);
    checkOutput("read_s_we", 64'(bus.s_we_o), 64'h0);
    applyStimulus(3'b001, 3'b001, 3'b001, 1'b0, 1'b1, 1'b0);
    checkOutput("write_m_err", 64'(bus.m_err_o), 64'h1);
    checkOutput("write_m_ack", 64'(bus.m_ack_o), 64'h0);
    checkOutput("write_s_we", 64'(bus.s_we_o), 64'h1);
    checkOutput("write_s_dat", 64'(bus.s_dat_o), 64'hA5A5_0000);
    checkOutput("write_s_sel", 64'(bus.s_sel_o), 64'hF);
    applyStimulus(3'b001, 3'b001, 3'b000, 1'b0, 1'b0, 1'b1);
    checkOutput("rty_m_rty", 64'(bus.m_rty_o), 64'h1);
    applyStimulus(3'b000, 3'b000, 3'b000, 1'b0, 1'b0, 1'b0);
    checkOutput("rty_release_grant", 64'(grant), 64'h1);

    // Reset in the middle of master 1's transfer. Master 0 then wins first.
    applyStimulus(3'b010, 3'b010, 3'b000, 1'b0, 1'b0, 1'b0);
    applyStimulus(3'b010, 3'b010, 3'b000, 1'b0, 1'b0, 1'b0);
    checkOutput("midrst_grant_before", 64'(grant), 64'h2);
    checkOutput("midrst_s_cyc_before", 64'(bus.s_cyc_o), 64'h1);
    rst = 1'b1;
    applyStimulus(3'b111, 3'b111, 3'b000, 1'b0, 1'b0, 1'b0);
    rst = 1'b0;
    checkOutput("midrst_grant_after", 64'(grant), 64'h0);
    checkOutput("midrst_s_cyc_after", 64'(bus.s_cyc_o), 64'h0);
    applyStimulus(3'b111, 3'b111, 3'b000, 1'b0, 1'b0, 1'b0);
    checkOutput("midrst_first_winner", 64'(grant), 64'h1);
    applyStimulus(3'b000, 3'b000, 3'b000, 1'b0, 1'b0, 1'b0);

`ifdef WB_ARB_WATCHDOG_EN
    // Master 0 hangs on a silent slave. An error pulses on the 16th GRANT
    // cycle, then the arbiter recovers after CYC drops.
    applyStimulus(3'b001, 3'b001, 3'b000, 1'b0, 1'b0, 1'b0);
    checkOutput("wdog_idle_grant", 64'(grant), 64'h0);
    for (int g = 1; g <= 15; g++) begin
      applyStimulus(3'b001, 3'b001, 3'b000, 1'b0, 1'b0, 1'b0);
      checkOutput("wdog_wait_m_err", 64'(bus.m_err_o), 64'h0);
      checkOutput("wdog_wait_s_cyc", 64'(bus.s_cyc_o), 64'h1);
    end
    applyStimulus(3'b001, 3'b001, 3'b000, 1'b0, 1'b0, 1'b0);
    checkOutput("wdog_fire_m_err", 64'(bus.m_err_o), 64'h1);
    checkOutput("wdog_fire_s_cyc", 64'(bus.s_cyc_o), 64'h0);
    applyStimulus(3'b001, 3'b001, 3'b000, 1'b1, 1'b0, 1'b0);
    checkOutput("wdog_recover_busy", 64'(busy), 64'h1);
    checkOutput("wdog_recover_s_cyc", 64'(bus.s_cyc_o), 64'h0);
    checkOutput("wdog_recover_m_ack", 64'(bus.m_ack_o), 64'h0);
    checkOutput("wdog_recover_m_err", 64'(bus.m_err_o), 64'h0);
    applyStimulus(3'b000, 3'b000, 3'b000, 1'b0, 1'b0, 1'b0);
    checkOutput("wdog_drop_busy", 64'(busy), 64'h1);
    applyStimulus(3'b000, 3'b000, 3'b000, 1'b0, 1'b0, 1'b0);
    checkOutput("wdog_idle_busy", 64'(busy), 64'h0);
    checkOutput("wdog_idle_grant2", 64'(grant), 64'h0);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end
endmodule
